reset_sequencer: RTL and testbench

//   Consumes the master clock and system reset and produces staged, per-domain

---
 rtl/reset_sequencer.sv | 178 +++++++++++++++++
 tb/tb_reset_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// ============================================================================
// reset_sequencer : synchronised, stretched, index-ordered per-domain reset release
// Optional ack timeout enabled by defining RSTSEQ_ACK_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module reset_sequencer #(
  parameter int NUM_DOMAINS    = 3,
  parameter int SYNC_STAGES    = 2,
  parameter int STRETCH_CYCLES = 16,
  parameter int STAGE_GAP      = 4,
  parameter int ACK_TIMEOUT    = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   soft_rst_req,
  input  logic [NUM_DOMAINS-1:0] dom_ack,
  output logic [NUM_DOMAINS-1:0] dom_rst_n,
  output logic                   sys_ready,
  output logic                   timeout_err,
  output logic [2:0]             seq_state
);

  localparam int MAX_SG = (STRETCH_CYCLES > STAGE_GAP) ? STRETCH_CYCLES : STAGE_GAP;
  localparam int MAXC   = (MAX_SG > ACK_TIMEOUT) ? MAX_SG : ACK_TIMEOUT;
  localparam int CW     = $clog2(MAXC + 1);
  localparam int IW     = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  localparam logic [IW-1:0] LAST_IDX    = IW'(NUM_DOMAINS - 1);
  localparam logic [CW-1:0] STRETCH_END = CW'(STRETCH_CYCLES - 1);
  localparam logic [CW-1:0] GAP_END     = CW'(STAGE_GAP - 1);

  typedef enum logic [2:0] {
    HOLD     = 3'd0,
    STRETCH  = 3'd1,
    RELEASE  = 3'd2,
    WAIT_ACK = 3'd3,
    GAP      = 3'd4,
    RUN      = 3'd5
  } state_t;

  state_t                 state, state_nx;
  logic [CW-1:0]          cnt, cnt_nx;
  logic [IW-1:0]          idx, idx_nx;
  logic [NUM_DOMAINS-1:0] dom_nx;
  logic                   ready_nx;
  logic [SYNC_STAGES-1:0] sync;
  logic                   srst;
  logic                   ack_go;

  // Only the deassertion of rst is synchronised; assertion clears everything at once.
  assign srst = sync[SYNC_STAGES-1];

`ifdef RSTSEQ_ACK_TIMEOUT_EN
  localparam logic [CW-1:0] TMO_END = CW'(ACK_TIMEOUT - 1);
  logic [CW-1:0] tmr, tmr_nx;
  logic          te_nx;
  logic          tmo_hit;
  assign tmo_hit = (tmr == TMO_END);
`else
  logic          tmo_hit;
  assign tmo_hit     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign ack_go    = dom_ack[idx] | tmo_hit;
  assign seq_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= HOLD;
      cnt       <= '0;
      idx       <= '0;
      dom_rst_n <= '0;
      sys_ready <= 1'b0;
      sync      <= '1;
`ifdef RSTSEQ_ACK_TIMEOUT_EN
      tmr         <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      idx       <= idx_nx;
      dom_rst_n <= dom_nx;
      sys_ready <= ready_nx;
      sync      <= {sync[SYNC_STAGES-2:0], 1'b0};
`ifdef RSTSEQ_ACK_TIMEOUT_EN
      tmr         <= tmr_nx;
      timeout_err <= te_nx;
`endif
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx;
    dom_nx   = dom_rst_n;
    ready_nx = sys_ready;
`ifdef RSTSEQ_ACK_TIMEOUT_EN
    tmr_nx   = tmr;
    te_nx    = timeout_err;
`endif
    if (soft_rst_req && (state != HOLD)) begin
      // Soft reset skips the synchroniser; the sticky timeout flag survives.
      state_nx = HOLD;
      cnt_nx   = '0;
      idx_nx   = '0;
      dom_nx   = '0;
      ready_nx = 1'b0;
    end else begin
      case (state)
        HOLD: begin
          if (!srst && !soft_rst_req) begin
            state_nx = STRETCH;
            cnt_nx   = '0;
          end
        end
        STRETCH: begin
          if (cnt == STRETCH_END) begin
            state_nx = RELEASE;
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
        RELEASE: begin
          dom_nx[idx] = 1'b1;
          state_nx    = WAIT_ACK;
`ifdef RSTSEQ_ACK_TIMEOUT_EN
          tmr_nx      = '0;
`endif
        end
        WAIT_ACK: begin
`ifdef RSTSEQ_ACK_TIMEOUT_EN
          if (tmo_hit) begin
            te_nx = 1'b1;
          end
`endif
          if (ack_go) begin
            if (idx == LAST_IDX) begin
              state_nx = RUN;
              ready_nx = 1'b1;
            end else begin
              state_nx = GAP;
              cnt_nx   = '0;
            end
          end else begin
`ifdef RSTSEQ_ACK_TIMEOUT_EN
            tmr_nx = tmr + CW'(1);
`endif
          end
        end
        GAP: begin
          if (cnt == GAP_END) begin
            idx_nx   = idx + IW'(1);
            state_nx = RELEASE;
          end else begin
            cnt_nx = cnt + CW'(1);
          end
        end
        RUN: begin
          dom_nx   = '1;
          ready_nx = 1'b1;
        end
        default: begin
          state_nx = HOLD;
          dom_nx   = '0;
          ready_nx = 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_reset_sequencer.sv
// ============================================================================
// tb_reset_sequencer : scoreboard bench; output-change events are queued by the
// stimulus and popped/compared by an independent negedge monitor.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_reset_sequencer;

  localparam int N = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         soft_rst_req;
  logic [N-1:0] dom_ack;
  logic [N-1:0] dom_rst_n;
  logic         sys_ready;
  logic         timeout_err;
  logic [2:0]   seq_state;

  reset_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .soft_rst_req (soft_rst_req),
    .dom_ack      (dom_ack),
    .dom_rst_n    (dom_rst_n),
    .sys_ready    (sys_ready),
    .timeout_err  (timeout_err),
    .seq_state    (seq_state)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Event = {timeout_err, sys_ready, dom_rst_n}; any_edge skips the timing check.
  typedef struct {
    int         at;
    logic [4:0] val;
    bit         any_edge;
  } ev_t;

  ev_t sb[$];
  int  checks = 0;
  int  errors = 0;
  bit  mon_en = 1'b0;
  logic [4:0] prev_obs = '0;

  always @(negedge clk) begin
    logic [4:0] cur;
    ev_t        e;
    cur = {timeout_err, sys_ready, dom_rst_n};
    if (mon_en && (cur !== prev_obs)) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event edge=%0d got=%b", edge_cnt, cur);
      end else begin
        e = sb.pop_front();
        if ((cur !== e.val) || (!e.any_edge && (edge_cnt != e.at))) begin
          errors++;
          $display("FAIL event got edge=%0d val=%b expected edge=%0d val=%b",
                   edge_cnt, cur, e.at, e.val);
        end
      end
    end
    prev_obs = cur;
  end

  task automatic push(input int at, input logic [4:0] val, input bit any_edge);
    ev_t e;
    e.at = at; e.val = val; e.any_edge = any_edge;
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic sb_empty(input string name);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s pending_events=%0d expected=0", name, sb.size());
    end
    sb.delete();
  endtask

  task automatic wait_edge(input int target);
    while (edge_cnt < target) @(negedge clk);
  endtask

  // Soft-reset pulse sampled on edge s; returns s.
  task automatic soft_pulse(output int s);
    @(negedge clk);
    soft_rst_req = 1'b1;
    s = edge_cnt + 1;
    @(negedge clk);
    soft_rst_req = 1'b0;
  endtask

  initial begin
    #60000;
    $display("FAIL watchdog edge=%0d", edge_cnt);
    $fatal(1);
  end

  initial begin
    int  base;
    int  s;
    int  t;
    logic te;

    rst = 1'b1; soft_rst_req = 1'b0; dom_ack = 3'b111;
    repeat (3) @(negedge clk);
    chk("reset_dom_rst_n", 8'(dom_rst_n), 8'h0);
    chk("reset_sys_ready", 8'(sys_ready), 8'h0);
    chk("reset_timeout_err", 8'(timeout_err), 8'h0);
    chk("reset_seq_state", 8'(seq_state), 8'h0);
    mon_en = 1'b1;

    // Power-on sequence, acks already high
    @(negedge clk);
    rst = 1'b0;
    base = edge_cnt;
    push(base + 20, 5'b00001, 0);
    push(base + 26, 5'b00011, 0);
    push(base + 32, 5'b00111, 0);
    push(base + 33, 5'b01111, 0);
    wait_edge(base + 40);
    chk("t1_seq_state_run", 8'(seq_state), 8'h5);
    sb_empty("t1_events");

    // One-cycle soft reset from RUN
    push(0, 5'b00000, 1);
    soft_pulse(s);
    sb.delete();
    push(s,      5'b00000, 0);
    push(s + 18, 5'b00001, 0);
    push(s + 24, 5'b00011, 0);
    push(s + 30, 5'b00111, 0);
    push(s + 31, 5'b01111, 0);
    wait_edge(s + 40);
    chk("t3_seq_state_run", 8'(seq_state), 8'h5);
    sb_empty("t3_events");

`ifdef RSTSEQ_ACK_TIMEOUT_EN
    // Domain 1 never acks: timeout forces progress
    dom_ack = 3'b101;
    push(0, 5'b00000, 1);
    soft_pulse(s);
    sb.delete();
    push(s,        5'b00000, 0);
    push(s + 18,   5'b00001, 0);
    push(s + 24,   5'b00011, 0);
    push(s + 280,  5'b10011, 0);
    push(0,        5'b10111, 1);
    push(0,        5'b11111, 1);
    wait_edge(s + 279);
    chk("t2_no_early_timeout", 8'(timeout_err), 8'h0);
    wait_edge(s + 310);
    chk("t2_timeout_err", 8'(timeout_err), 8'h1);
    chk("t2_seq_state_run", 8'(seq_state), 8'h5);
    sb_empty("t2_events");
    dom_ack = 3'b111;
    te = 1'b1;
`else
    // Domain 0 withholds ack; other domains' acks must be ignored
    dom_ack = 3'b110;
    push(0, 5'b00000, 1);
    soft_pulse(s);
    sb.delete();
    push(s,      5'b00000, 0);
    push(s + 18, 5'b00001, 0);
    wait_edge(s + 1018);
    chk("t5_seq_state_wait", 8'(seq_state), 8'h3);
    chk("t5_timeout_err", 8'(timeout_err), 8'h0);
    @(negedge clk);
    dom_ack = 3'b111;
    t = edge_cnt;
    push(t + 6,  5'b00011, 0);
    push(t + 12, 5'b00111, 0);
    push(t + 13, 5'b01111, 0);
    wait_edge(t + 20);
    chk("t5_seq_state_run", 8'(seq_state), 8'h5);
    sb_empty("t5_events");
    te = 1'b0;
`endif

    // Async rst while in GAP after domain 0
    push(0, {te, 4'b0000}, 1);
    soft_pulse(s);
    sb.delete();
    push(s,      {te, 4'b0000}, 0);
    push(s + 18, {te, 4'b0001}, 0);
    push(0,      5'b00000, 1);
    wait_edge(s + 20);
    chk("t4_in_gap", 8'(seq_state), 8'h4);
    #2 rst = 1'b1;
    #1;
    chk("t4_async_dom_rst_n", 8'(dom_rst_n), 8'h0);
    chk("t4_async_sys_ready", 8'(sys_ready), 8'h0);
    chk("t4_async_timeout_err", 8'(timeout_err), 8'h0);
    chk("t4_async_seq_state", 8'(seq_state), 8'h0);
    @(negedge clk);
    rst = 1'b0;
    base = edge_cnt;
    push(base + 20, 5'b00001, 0);
    push(base + 26, 5'b00011, 0);
    push(base + 32, 5'b00111, 0);
    push(base + 33, 5'b01111, 0);
    wait_edge(base + 40);
    chk("t4_seq_state_run", 8'(seq_state), 8'h5);
    sb_empty("t4_events");

    // Soft request held across a hard reset keeps the sequencer in HOLD
    push(0, 5'b00000, 1);
    @(negedge clk);
    #2 rst = 1'b1;
    soft_rst_req = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("t6_hold", 8'(seq_state), 8'h0);
    end
    soft_rst_req = 1'b0;
    t = edge_cnt;
    push(t + 18, 5'b00001, 0);
    push(t + 24, 5'b00011, 0);
    push(t + 30, 5'b00111, 0);
    push(t + 31, 5'b01111, 0);
    wait_edge(t + 40);
    chk("t6_seq_state_run", 8'(seq_state), 8'h5);
    sb_empty("t6_events");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
